// File: rtl/rx_anc_pkg.sv
//------------------------------------------------------------------------------
// rx_anc_pkg : shared types and constants for the RX ANC hop sequencer/datapath
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rx_anc_pkg;

    localparam int DEF_PHASE_WIDTH = 24;
    localparam int DEF_NSIG_WIDTH  = 24;
    localparam int DEF_NSYMB_WIDTH = 16;

    localparam logic [DEF_PHASE_WIDTH-1:0] RX_ANC_START_PH = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rx_anc_state_e;

endpackage

`default_nettype wire

// File: rtl/rx_anc_beat_counter.sv
//------------------------------------------------------------------------------
// rx_anc_beat_counter : sample/symbol counter pair with registered terminal flags
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rx_anc_beat_counter
    import rx_anc_pkg::*;
#(
    parameter int NSIG_WIDTH  = DEF_NSIG_WIDTH,
    parameter int NSYMB_WIDTH = DEF_NSYMB_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic [NSIG_WIDTH-1:0]  cfg_nsig_i,
    input  logic [NSYMB_WIDTH-1:0] cfg_nsymb_i,
    output logic                   last_samp_o,
    output logic                   last_samp_d_o,
    output logic                   last_symb_o,
    output logic [NSYMB_WIDTH-1:0] symb_count_o
);

    logic [NSIG_WIDTH-1:0]  samp_term_q;
    logic [NSYMB_WIDTH-1:0] nsymb_q;
    logic [NSIG_WIDTH-1:0]  samp_cnt_q,  samp_cnt_d;
    logic [NSYMB_WIDTH-1:0] symb_cnt_q,  symb_cnt_d;
    logic                   last_samp_q, last_samp_d;
    logic [NSIG_WIDTH-1:0]  w_load_term;

    // Terminal sample index is nsig-1, with nsig==0 folded onto 1.
    assign w_load_term = (cfg_nsig_i == '0) ? '0 : cfg_nsig_i - NSIG_WIDTH'(1);

    always_comb begin
        samp_cnt_d  = samp_cnt_q;
        symb_cnt_d  = symb_cnt_q;
        last_samp_d = last_samp_q;
        if (load_i) begin
            samp_cnt_d  = '0;
            symb_cnt_d  = '0;
            last_samp_d = (w_load_term == '0);
        end else if (en_i) begin
            if (last_samp_q) begin
                samp_cnt_d  = '0;
                symb_cnt_d  = symb_cnt_q + NSYMB_WIDTH'(1);
                last_samp_d = (samp_term_q == '0);
            end else begin
                samp_cnt_d  = samp_cnt_q + NSIG_WIDTH'(1);
                last_samp_d = ((samp_cnt_q + NSIG_WIDTH'(1)) == samp_term_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_term_q <= '0;
            nsymb_q     <= '0;
            samp_cnt_q  <= '0;
            symb_cnt_q  <= '0;
            last_samp_q <= 1'b0;
        end else begin
            if (load_i) begin
                samp_term_q <= w_load_term;
                nsymb_q     <= cfg_nsymb_i;
            end
            samp_cnt_q  <= samp_cnt_d;
            symb_cnt_q  <= symb_cnt_d;
            last_samp_q <= last_samp_d;
        end
    end

    // nsymb==0 is continuous mode: never the last symbol.
    assign last_symb_o   = (nsymb_q != '0) && (symb_cnt_q == (nsymb_q - NSYMB_WIDTH'(1)));
    assign last_samp_o   = last_samp_q;
    assign last_samp_d_o = last_samp_d;
    assign symb_count_o  = symb_cnt_q;

endmodule

`default_nettype wire

// File: rtl/rx_anc_hop_ctrl.sv
//------------------------------------------------------------------------------
// rx_anc_hop_ctrl : phase-word sequencer with per-symbol frequency hopping
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rx_anc_hop_ctrl
    import rx_anc_pkg::*;
#(
    parameter int                     PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int                     NSIG_WIDTH  = DEF_NSIG_WIDTH,
    parameter int                     NSYMB_WIDTH = DEF_NSYMB_WIDTH,
    parameter logic [PHASE_WIDTH-1:0] START_PH    = PHASE_WIDTH'(RX_ANC_START_PH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NSIG_WIDTH-1:0]  cfg_nsig,
    input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
    input  logic [PHASE_WIDTH-1:0] cfg_dph_inc,
    input  logic [PHASE_WIDTH-1:0] cfg_dph_step,
    input  logic                   start,
    input  logic                   abort,
    output logic                   srst,
    output logic [PHASE_WIDTH-1:0] phase_tdata,
    output logic                   phase_tvalid,
    output logic                   phase_tlast,
    input  logic                   phase_tready,
    output logic                   busy,
    output logic                   done,
    output logic [NSYMB_WIDTH-1:0] symb_count
);

    rx_anc_state_e          state_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [PHASE_WIDTH-1:0] inc_q;
    logic [PHASE_WIDTH-1:0] step_q;
    logic                   tvalid_q;
    logic                   tlast_q;
    logic                   srst_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   abort_q;

    logic w_load;
    logic w_hs;
    logic w_abort;
    logic w_last_samp;
    logic w_last_samp_d;
    logic w_last_symb;
    logic w_burst_end;

    assign w_load      = (state_q == ST_IDLE) && start;
    assign w_hs        = (state_q == ST_RUN) && tvalid_q && phase_tready;
    assign w_abort     = abort || abort_q;
    assign w_burst_end = w_last_samp && w_last_symb;

    rx_anc_beat_counter #(
        .NSIG_WIDTH  (NSIG_WIDTH),
        .NSYMB_WIDTH (NSYMB_WIDTH)
    ) u_beat_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_i        (w_load),
        .en_i          (w_hs),
        .cfg_nsig_i    (cfg_nsig),
        .cfg_nsymb_i   (cfg_nsymb),
        .last_samp_o   (w_last_samp),
        .last_samp_d_o (w_last_samp_d),
        .last_symb_o   (w_last_symb),
        .symb_count_o  (symb_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= START_PH;
            inc_q    <= '0;
            step_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            srst_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            srst_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        phase_q  <= START_PH;
                        inc_q    <= cfg_dph_inc;
                        step_q   <= cfg_dph_step;
                        tvalid_q <= 1'b1;
                        tlast_q  <= w_last_samp_d;
                        srst_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        abort_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        if (w_last_samp) begin
                            phase_q <= START_PH;
                            inc_q   <= inc_q + step_q;
                        end else begin
                            phase_q <= phase_q + inc_q;
                        end
                        if (w_abort || w_burst_end) begin
                            state_q  <= ST_DONE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            abort_q  <= 1'b0;
                        end else begin
                            tlast_q <= w_last_samp_d;
                        end
                    end else if (w_abort) begin
                        // Stalled beat is kept but closed out as the final one.
                        abort_q <= 1'b1;
                        tlast_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign srst         = srst_q;
    assign phase_tdata  = phase_q;
    assign phase_tvalid = tvalid_q;
    assign phase_tlast  = tlast_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_anc_hop_ctrl.sv
//------------------------------------------------------------------------------
// tb_rx_anc_hop_ctrl : self-checking bench for rx_anc_hop_ctrl
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rx_anc_hop_ctrl;

    localparam logic [23:0] C_START_PH = 24'h000000;

    logic        clk;
    logic        reset_n;
    logic [23:0] cfg_nsig;
    logic [15:0] cfg_nsymb;
    logic [23:0] cfg_dph_inc;
    logic [23:0] cfg_dph_step;
    logic        start;
    logic        abort;
    logic        srst;
    logic [23:0] phase_tdata;
    logic        phase_tvalid;
    logic        phase_tlast;
    logic        phase_tready;
    logic        busy;
    logic        done;
    logic [15:0] symb_count;

    rx_anc_hop_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_nsig     (cfg_nsig),
        .cfg_nsymb    (cfg_nsymb),
        .cfg_dph_inc  (cfg_dph_inc),
        .cfg_dph_step (cfg_dph_step),
        .start        (start),
        .abort        (abort),
        .srst         (srst),
        .phase_tdata  (phase_tdata),
        .phase_tvalid (phase_tvalid),
        .phase_tlast  (phase_tlast),
        .phase_tready (phase_tready),
        .busy         (busy),
        .done         (done),
        .symb_count   (symb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int srst_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (srst) srst_cnt <= srst_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // Results of the most recent burst
    logic [24:0] beats[$];
    logic [24:0] exp_q[$];
    int          stall_err;
    int          done_gap;
    bit          timed_out;
    logic        first_srst, first_busy, first_valid;
    logic [23:0] first_data;
    logic [15:0] symb_at_done;
    logic        post_busy, post_done;

    // Reference: symbol s uses increment inc + s*step; sample k has phase START + k*inc_s.
    task automatic build_exp(input logic [23:0] nsig, input logic [15:0] nsymb,
                             input logic [23:0] inc, input logic [23:0] step);
        int n;
        logic [23:0] sv, kv, inc_s, ph;
        exp_q.delete();
        n = (nsig == 0) ? 1 : int'(nsig);
        for (int s = 0; s < int'(nsymb); s++) begin
            sv    = 24'(s);
            inc_s = inc + sv * step;
            for (int k = 0; k < n; k++) begin
                kv = 24'(k);
                ph = C_START_PH + kv * inc_s;
                exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, ph});
            end
        end
    endtask

    // Starts a burst at the current negedge and collects accepted beats until done.
    task automatic drive_burst(input logic [23:0] nsig, input logic [15:0] nsymb,
                               input logic [23:0] inc, input logic [23:0] step,
                               input int rdy_pct, input int max_cyc, input int start_cyc);
        int          cyc;
        int          last_hs;
        bit          fin;
        bit          held;
        logic [23:0] hd;
        logic        hl;
        beats.delete();
        stall_err = 0;
        timed_out = 1'b0;
        done_gap  = -1;
        cyc       = 0;
        last_hs   = -100;
        fin       = 1'b0;
        held      = 1'b0;
        hd        = '0;
        hl        = 1'b0;
        cfg_nsig     = nsig;
        cfg_nsymb    = nsymb;
        cfg_dph_inc  = inc;
        cfg_dph_step = step;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin) begin
            if (cyc == 0) begin
                first_srst  = srst;
                first_busy  = busy;
                first_valid = phase_tvalid;
                first_data  = phase_tdata;
            end
            if (held && (!phase_tvalid || phase_tdata !== hd || phase_tlast !== hl))
                stall_err++;
            if (done) begin
                fin          = 1'b1;
                done_gap     = cyc - last_hs;
                symb_at_done = symb_count;
            end else if (cyc >= max_cyc) begin
                fin       = 1'b1;
                timed_out = 1'b1;
            end else begin
                if (cyc == start_cyc) begin
                    start        = 1'b1;
                    cfg_nsig     = 24'd7;
                    cfg_nsymb    = 16'd9;
                    cfg_dph_inc  = 24'h00ABCD;
                    cfg_dph_step = 24'h001111;
                end else begin
                    start = 1'b0;
                end
                phase_tready = ($urandom_range(99) < rdy_pct);
                held = phase_tvalid && !phase_tready;
                hd   = phase_tdata;
                hl   = phase_tlast;
                if (phase_tvalid && phase_tready) begin
                    beats.push_back({phase_tlast, phase_tdata});
                    last_hs = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start        = 1'b0;
        phase_tready = 1'b0;
        @(negedge clk);
        post_busy = busy;
        post_done = done;
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        phase_tready = 1'b0;
        cfg_nsig     = '0;
        cfg_nsymb    = '0;
        cfg_dph_inc  = '0;
        cfg_dph_step = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({phase_tvalid, phase_tlast, srst, busy, done} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {phase_tvalid, phase_tlast, srst, busy, done});
        else n_pass++;
        n_checks++;
        if (phase_tdata !== C_START_PH) $display("FAIL reset_tdata got %h want %h", phase_tdata, C_START_PH);
        else n_pass++;
        n_checks++;
        if (symb_count !== 16'd0) $display("FAIL reset_symb got %0d want 0", symb_count);
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({phase_tvalid, busy, done, srst} !== 4'b0)
            $display("FAIL idle_after_reset got %b want 0000", {phase_tvalid, busy, done, srst});
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [23:0] req[8];
        int s0;
        req[0] = 24'h000; req[1] = 24'h100; req[2] = 24'h200; req[3] = 24'h300;
        req[4] = 24'h000; req[5] = 24'h200; req[6] = 24'h400; req[7] = 24'h600;
        s0 = srst_cnt;
        drive_burst(24'd4, 16'd2, 24'h100, 24'h100, 100, 100, -1);
        n_checks++;
        if ({first_srst, first_busy, first_valid} !== 3'b111 || first_data !== C_START_PH)
            $display("FAIL basic_first got srst/busy/valid=%b data=%h want 111 %h",
                     {first_srst, first_busy, first_valid}, first_data, C_START_PH);
        else n_pass++;
        n_checks++;
        if (beats.size() != 8 || timed_out) $display("FAIL basic_count got %0d want 8", beats.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            n_checks++;
            if (beats[i] !== {(i == 3 || i == 7) ? 1'b1 : 1'b0, req[i]})
                $display("FAIL basic_beat%0d got %h want %h", i, beats[i], {(i == 3 || i == 7) ? 1'b1 : 1'b0, req[i]});
            else n_pass++;
        end
        n_checks++;
        if (done_gap != 1) $display("FAIL basic_done_latency got %0d want 1", done_gap);
        else n_pass++;
        n_checks++;
        if (symb_at_done !== 16'd2) $display("FAIL basic_symb_count got %0d want 2", symb_at_done);
        else n_pass++;
        n_checks++;
        if ({post_busy, post_done} !== 2'b00) $display("FAIL basic_idle got %b want 00", {post_busy, post_done});
        else n_pass++;
        n_checks++;
        if (srst_cnt - s0 != 1) $display("FAIL basic_srst got %0d want 1", srst_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        build_exp(24'd4, 16'd2, 24'h100, 24'h100);
        drive_burst(24'd4, 16'd2, 24'h100, 24'h100, 45, 400, -1);
        n_checks++;
        if (beats.size() != exp_q.size() || timed_out)
            $display("FAIL bp_count got %0d want %0d", beats.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            n_checks++;
            if (beats[i] !== exp_q[i]) $display("FAIL bp_beat%0d got %h want %h", i, beats[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (stall_err != 0) $display("FAIL bp_hold got %0d changes want 0", stall_err);
        else n_pass++;
    endtask

    task automatic test_wrap_edge;
        drive_burst(24'd3, 16'd1, 24'hFFFF00, 24'h000001, 100, 100, -1);
        n_checks++;
        if (beats.size() != 3 || beats[0] !== {1'b0, 24'h000000} || beats[1] !== {1'b0, 24'hFFFF00}
            || beats[2] !== {1'b1, 24'hFFFE00})
            $display("FAIL wrap_beats got n=%0d %p want 0 FFFF00 FFFE00", beats.size(), beats);
        else n_pass++;
        drive_burst(24'd0, 16'd4, 24'h000123, 24'h000045, 100, 100, -1);
        n_checks++;
        if (beats.size() != 4) $display("FAIL nsig0_count got %0d want 4", beats.size());
        else n_pass++;
        for (int i = 0; i < beats.size(); i++) begin
            n_checks++;
            if (beats[i] !== {1'b1, C_START_PH}) $display("FAIL nsig0_beat%0d got %h want %h", i, beats[i], {1'b1, C_START_PH});
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [23:0] nsig, inc, step;
        logic [15:0] nsymb;
        int bad;
        for (int it = 0; it < 8; it++) begin
            nsig  = 24'($urandom_range(6, 0));
            nsymb = 16'($urandom_range(4, 1));
            inc   = 24'($urandom);
            step  = 24'($urandom);
            build_exp(nsig, nsymb, inc, step);
            drive_burst(nsig, nsymb, inc, step, 60, 600, -1);
            bad = 0;
            for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
                if (beats[i] !== exp_q[i]) bad++;
            n_checks++;
            if (bad != 0 || beats.size() != exp_q.size() || timed_out || stall_err != 0)
                $display("FAIL rand%0d got n=%0d bad=%0d hold=%0d want n=%0d bad=0 hold=0",
                         it, beats.size(), bad, stall_err, exp_q.size());
            else n_pass++;
            n_checks++;
            if (symb_at_done !== nsymb) $display("FAIL rand%0d_symb got %0d want %0d", it, symb_at_done, nsymb);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored;
        int s0;
        s0 = srst_cnt;
        build_exp(24'd2, 16'd3, 24'h000400, 24'hFFFF00);
        drive_burst(24'd2, 16'd3, 24'h000400, 24'hFFFF00, 100, 100, 2);
        n_checks++;
        if (beats.size() != exp_q.size()) $display("FAIL ign_count got %0d want %0d", beats.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            n_checks++;
            if (beats[i] !== exp_q[i]) $display("FAIL ign_beat%0d got %h want %h", i, beats[i], exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if (srst_cnt - s0 != 1) $display("FAIL ign_srst got %0d want 1", srst_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = srst_cnt;
        drive_burst(24'd2, 16'd1, 24'h000010, 24'h000001, 100, 100, -1);
        drive_burst(24'd1, 16'd2, 24'h000020, 24'h000002, 100, 100, -1);
        n_checks++;
        if (first_srst !== 1'b1 || first_valid !== 1'b1 || beats.size() != 2)
            $display("FAIL b2b_second got srst=%b valid=%b n=%0d want 1 1 2", first_srst, first_valid, beats.size());
        else n_pass++;
        n_checks++;
        if (srst_cnt - s0 != 2) $display("FAIL b2b_srst got %0d want 2", srst_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_abort;
        logic [23:0] inc;
        logic [23:0] want;
        inc  = 24'($urandom);
        want = C_START_PH + 24'd2 * inc;
        cfg_nsig = 24'd8; cfg_nsymb = 16'd0; cfg_dph_inc = inc; cfg_dph_step = 24'h000001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        phase_tready = 1'b1;
        repeat (2) @(negedge clk);
        phase_tready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({phase_tvalid, phase_tlast, done} !== 3'b110 || phase_tdata !== want)
                $display("FAIL abort_hold%0d got v/l/d=%b data=%h want 110 %h",
                         k, {phase_tvalid, phase_tlast, done}, phase_tdata, want);
            else n_pass++;
            if (k == 1) phase_tready = 1'b1;
            @(negedge clk);
        end
        phase_tready = 1'b0;
        n_checks++;
        if ({done, phase_tvalid} !== 2'b10) $display("FAIL abort_done got %b want 10", {done, phase_tvalid});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) $display("FAIL abort_idle got %b want 00", {done, busy});
        else n_pass++;
    endtask

    task automatic test_continuous;
        int bad;
        cfg_nsig = 24'd1; cfg_nsymb = 16'd0; cfg_dph_inc = 24'h000055; cfg_dph_step = 24'h000003;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        phase_tready = 1'b1;
        n_checks++;
        if (symb_count !== 16'd0) $display("FAIL cont_symb0 got %0d want 0", symb_count);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 70010; i++) begin
            if (!phase_tvalid || !phase_tlast || phase_tdata !== C_START_PH || done) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) $display("FAIL cont_beats got %0d bad beats want 0", bad);
        else n_pass++;
        n_checks++;
        if (symb_count !== 16'd4474) $display("FAIL cont_wrap got %0d want 4474", symb_count);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        phase_tready = 1'b0;
        n_checks++;
        if ({done, phase_tvalid} !== 2'b10) $display("FAIL cont_abort got %b want 10", {done, phase_tvalid});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midburst;
        int d0;
        cfg_nsig = 24'd5; cfg_nsymb = 16'd3; cfg_dph_inc = 24'h000777; cfg_dph_step = 24'h000100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        phase_tready = 1'b1;
        repeat (7) @(negedge clk);
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({phase_tvalid, phase_tlast, srst, busy, done} !== 5'b0 || phase_tdata !== C_START_PH
            || symb_count !== 16'd0)
            $display("FAIL midrst got flags=%b data=%h symb=%0d want 00000 %h 0",
                     {phase_tvalid, phase_tlast, srst, busy, done}, phase_tdata, symb_count, C_START_PH);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        phase_tready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || busy !== 1'b0 || phase_tvalid !== 1'b0)
            $display("FAIL midrst_nodone got done_pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_edge();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_reset_midburst();
        test_continuous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
